lm32_ram: RTL and testbench
===========================

// Module: lm32_ram
// PURPOSE
//   Generic simple-dual-port RAM: one write port, one read port, single clock domain.
//   The read address is registered and the array is read combinationally.
//   Used by the LM32 caches and TLBs. Example: the DTLB stores {valid, tag, PFN} words.
//   It then gets a single-cycle lookup indexed from the X-stage address, with data valid in M.
// PARAMETERS
//   data_width     32   bits per word (DTLB instance: 31)
//   address_width  10   address bits; depth = 2**address_width words
// PORTS
//   read_clk       in   1    read-port clock; tied to the same clock as write_clk
//   write_clk      in   1    write-port clock (clk_i); block is single-clock
//   reset          in   1    synchronous, active-high reset
//   read_address   in   address_width  read word address
//   enable_read    in   1    1: capture read_address at clock edge
//   write_address  in   address_width  write word address
//   enable_write   in   1    write-port enable (clock-enable qualifier)
//   write_enable   in   1    write strobe
//   write_data     in   data_width     data to store
//   read_data      out  data_width     mem[registered read address]
// BEHAVIOUR
//   - One clock, synchronous active-high reset; read_clk and write_clk are driven by the same clock.
//     All updates occur on its rising edge.
//   - Storage: array mem[0 .. 2**address_width-1] of data_width bits.
//     All words initialise to 0 at configuration. Reset does NOT clear the array.
//   - Read-address register ra:
//       * reset=1: ra <= 0.
//       * else if enable_read=1: ra <= read_address.
//       * else: ra holds its value.
//   - read_data = mem[ra], combinational from ra and the array contents.
//       * Latency: 1 clock from read_address to read_data.
//       * With enable_read=0, read_data keeps reflecting the held address.
//   - Write: on an edge with reset=0, enable_write=1 and write_enable=1: mem[write_address] <= write_data.
//       * Otherwise the array is unchanged.
//       * While reset=1, writes are suppressed.
//   - Read-during-write on the same address: write-first.
//       * After edge N writes D to A with ra==A (newly captured or held), read_data = D immediately after edge N.
//       * Old data is never returned after that edge.
//   - Reset value of read_data: mem[0], since ra=0.
//   - Widths: addresses are used as unsigned full-range values with no bounds check.
//     The last index 2**address_width-1 is valid.
//   - Simultaneous read and write to different addresses are independent; neither port stalls.
//   - No handshake; the read port is always ready. X/undefined inputs are not guarded.
// TESTING
//   1. Write/read:
//      - Stimulus: write 0x12345678 to addr 5, then enable_read with addr 5.
//      - Response: read_data = 0x12345678 one edge after capture.
//   2. Write-first:
//      - Stimulus: same edge sets ra<=7 and writes 0xA5A5A5A5 to 7.
//      - Response: read_data = 0xA5A5A5A5 right after that edge.
//   3. Hold:
//      - Stimulus: ra=3 with enable_read=0; change read_address to 9, then write 0x55 to 3.
//      - Response: read_data follows mem[3] and shows 0x55 after the write edge; addr 9 is ignored.
//   4. Write gating:
//      - Stimulus: write_enable=1, enable_write=0 to addr 2.
//      - Response: mem[2] unchanged (reads the prior value 0).
//      - Stimulus: write with reset=1.
//      - Response: no change.
//   5. Reset:
//      - Stimulus: after writing 0xDEAD to addr 0 and 0xBEEF to addr 4 with ra=4, pulse reset 1 cycle.
//      - Response: read_data = 0xDEAD and mem[4] still 0xBEEF.
//   6. Boundary/DTLB config:
//      - Stimulus: data_width=31, address_width=10; write {1'b1, tag, pfn} to addr 1023, then addr 0; read both.
//      - Response: exact words returned; no aliasing.

Source files
------------

// File: rtl/lm32_ram.sv
// Simple-dual-port RAM with a registered read address and combinational array read.
// Write-first on address collision falls out of reading the array after the write edge.
module lm32_ram #(
  parameter int unsigned data_width    = 32,
  parameter int unsigned address_width = 10
) (
  input  logic                     read_clk,
  input  logic                     write_clk,
  input  logic                     reset,
  input  logic [address_width-1:0] read_address,
  input  logic                     enable_read,
  input  logic [address_width-1:0] write_address,
  input  logic                     enable_write,
  input  logic                     write_enable,
  input  logic [data_width-1:0]    write_data,
  output logic [data_width-1:0]    read_data
);

  localparam int unsigned Depth = 32'd1 << address_width;

  // Array contents come up as zero at configuration; reset never touches them.
  logic [data_width-1:0]    mem_q [Depth] = '{default: '0};
  logic [address_width-1:0] ra_q;
  logic [address_width-1:0] ra_d;

  // Read-address capture: load on enable_read, otherwise hold.
  always_comb begin
    ra_d = ra_q;
    if (enable_read) begin
      ra_d = read_address;
    end
  end

  always_ff @(posedge read_clk) begin
    if (reset) begin
      ra_q <= '0;
    end else begin
      ra_q <= ra_d;
    end
  end

  // Write port: both qualifiers required, suppressed during reset.
  always_ff @(posedge write_clk) begin
    if (!reset && enable_write && write_enable) begin
      mem_q[write_address] <= write_data;
    end
  end

  assign read_data = mem_q[ra_q];

endmodule

// File: tb/tb_lm32_ram.sv
// Self-checking bench for lm32_ram: directed scenarios plus a randomised
// back-to-back run, with expected read data queued in a scoreboard.
module tb_lm32_ram;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  read_address, write_address;
  logic        enable_read, enable_write, write_enable;
  logic [31:0] write_data, read_data;

  logic [9:0]  t_read_address, t_write_address;
  logic        t_enable_read, t_enable_write, t_write_enable;
  logic [30:0] t_write_data, t_read_data;

  int checks   = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [31:0] model [1024];
  logic [9:0]  model_ra;

  always #5 clk = ~clk;

  lm32_ram #(.data_width(32), .address_width(10)) dut (
    .read_clk(clk), .write_clk(clk), .reset(reset),
    .read_address(read_address), .enable_read(enable_read),
    .write_address(write_address), .enable_write(enable_write),
    .write_enable(write_enable), .write_data(write_data),
    .read_data(read_data)
  );

  lm32_ram #(.data_width(31), .address_width(10)) dut_dtlb (
    .read_clk(clk), .write_clk(clk), .reset(reset),
    .read_address(t_read_address), .enable_read(t_enable_read),
    .write_address(t_write_address), .enable_write(t_enable_write),
    .write_enable(t_write_enable), .write_data(t_write_data),
    .read_data(t_read_data)
  );

  // One clock of stimulus on the 32-bit instance; the reference model tracks it.
  task automatic drive(input logic rst, input logic er, input logic [9:0] ra,
                       input logic ew, input logic we, input logic [9:0] wa,
                       input logic [31:0] wd);
    reset = rst; enable_read = er; read_address = ra;
    enable_write = ew; write_enable = we; write_address = wa; write_data = wd;
    if (rst) begin
      model_ra = '0;
    end else begin
      if (er) model_ra = ra;
      if (ew && we) model[wa] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    sb.push_back('{"reset_rd", 32'h0});
    sb.push_back('{"reset_rd31", 32'h0});
    drive(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0);
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
    e = sb.pop_front(); checks++;
    if ({1'b0, t_read_data} !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, t_read_data, e.exp);
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    sb.push_back('{"wr_ra0_unchanged", 32'h0});
    drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd5, 32'h1234_5678);
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
    sb.push_back('{"write_read_5", 32'h1234_5678});
    drive(1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0);
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
  endtask

  task automatic test_write_first();
    exp_t e;
    sb.push_back('{"write_first_7", 32'hA5A5_A5A5});
    drive(1'b0, 1'b1, 10'd7, 1'b1, 1'b1, 10'd7, 32'hA5A5_A5A5);
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd9, 32'h0000_0099);
    sb.push_back('{"hold_capture_3", 32'h0});
    drive(1'b0, 1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'h0);
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
    sb.push_back('{"hold_ignore_9", 32'h0});
    drive(1'b0, 1'b0, 10'd9, 1'b0, 1'b0, 10'd0, 32'h0);
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
    sb.push_back('{"hold_write_3", 32'h0000_0055});
    drive(1'b0, 1'b0, 10'd9, 1'b1, 1'b1, 10'd3, 32'h0000_0055);
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
  endtask

  task automatic test_write_gating();
    exp_t e;
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 10'd2, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd2, 32'hEEEE_EEEE);
    sb.push_back('{"gate_reset_ra0", 32'h0});
    drive(1'b1, 1'b1, 10'd2, 1'b1, 1'b1, 10'd2, 32'h0000_0077);
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
    sb.push_back('{"gate_mem2", 32'h0});
    drive(1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 10'd0, 32'h0);
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
  endtask

  task automatic test_reset_keeps_mem();
    exp_t e;
    drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd0, 32'h0000_DEAD);
    sb.push_back('{"rst_pre_4", 32'h0000_BEEF});
    drive(1'b0, 1'b1, 10'd4, 1'b1, 1'b1, 10'd4, 32'h0000_BEEF);
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
    sb.push_back('{"rst_reads_0", 32'h0000_DEAD});
    drive(1'b1, 1'b0, 10'd4, 1'b0, 1'b0, 10'd0, 32'h0);
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
    sb.push_back('{"rst_keeps_4", 32'h0000_BEEF});
    drive(1'b0, 1'b1, 10'd4, 1'b0, 1'b0, 10'd0, 32'h0);
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
  endtask

  task automatic test_boundary();
    exp_t        e;
    logic [30:0] w_hi, w_lo;
    w_hi = {1'b1, 10'h2B3, 20'hC0FFE};
    w_lo = {1'b1, 10'h155, 20'h12345};
    t_enable_read = 1'b0; t_enable_write = 1'b1; t_write_enable = 1'b1;
    t_write_address = 10'd1023; t_write_data = w_hi;
    drive(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd1023, 32'hCAFE_F00D);
    t_write_address = 10'd0; t_write_data = w_lo;
    @(posedge clk); #1;
    t_enable_write = 1'b0; t_enable_read = 1'b1; t_read_address = 10'd1023;
    sb.push_back('{"dtlb_1023", {1'b0, w_hi}});
    sb.push_back('{"top_1023", 32'hCAFE_F00D});
    drive(1'b0, 1'b1, 10'd1023, 1'b0, 1'b0, 10'd0, 32'h0);
    e = sb.pop_front(); checks++;
    if ({1'b0, t_read_data} !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, t_read_data, e.exp);
    end
    e = sb.pop_front(); checks++;
    if (read_data !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, read_data, e.exp);
    end
    t_read_address = 10'd0;
    sb.push_back('{"dtlb_0", {1'b0, w_lo}});
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if ({1'b0, t_read_data} !== e.exp) begin
      failures++; $display("FAIL %s: got %h expected %h", e.name, t_read_data, e.exp);
    end
    t_enable_read = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic        er, ew, we;
    logic [9:0]  ra, wa;
    logic [31:0] wd;
    for (int i = 0; i < 80; i++) begin
      er = 1'($urandom_range(0, 1));
      ew = 1'($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 3) != 0);
      ra = 10'($urandom_range(0, 15));
      wa = 10'($urandom_range(0, 15));
      wd = $urandom;
      drive(1'b0, er, ra, ew, we, wa, wd);
      sb.push_back('{"b2b", model[model_ra]});
      e = sb.pop_front(); checks++;
      if (read_data !== e.exp) begin
        failures++;
        $display("FAIL %s[%0d]: got %h expected %h ra=%0d", e.name, i, read_data, e.exp, model_ra);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = '0;
    model_ra = '0;
    t_enable_read = 1'b0; t_read_address = '0; t_enable_write = 1'b0;
    t_write_enable = 1'b0; t_write_address = '0; t_write_data = '0;
    #1;
    test_reset();
    test_write_read();
    test_write_first();
    test_hold();
    test_write_gating();
    test_reset_keeps_mem();
    test_boundary();
    test_back_to_back();
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
